// File: rtl/mdu_ex_if.sv
// Bus between the EX-stage control and the multiply/divide unit: operands,
// opcode and cancel in; busy flag, HI/LO and the mfhi/mflo read value out.
interface mdu_ex_if;
  logic        start;
  logic [3:0]  md_op;
  logic [31:0] num1;
  logic [31:0] num2;
  logic        req;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rd_data;

  modport master (
    output start, md_op, num1, num2, req,
    input  busy, hi, lo, rd_data
  );

  modport slave (
    input  start, md_op, num1, num2, req,
    output busy, hi, lo, rd_data
  );
endinterface

// File: rtl/mdu_ex.sv
// EX-stage multiply/divide unit holding HI/LO, with a fixed-latency busy window.
// Define MDU_MADD_EN to enable madd/maddu/msub/msubu (ops 9-12).
module mdu_ex #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic       clk,
  input logic       reset,
  mdu_ex_if.slave   bus
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;
`endif

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [31:0]      pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic             pend_wr_q, pend_wr_d;
  logic [31:0]      rd_data_s;

  logic [63:0] smul_s, umul_s;
  logic        div0_s, a_neg_s, b_neg_s;
  logic [31:0] abs_a_s, abs_b_s, uq_s, ur_s, mq_s, mr_s, sq_s, sr_s;

  // Signed divide works on magnitudes so 0x80000000 / -1 yields 0x80000000 rem 0.
  assign smul_s  = $signed({{32{bus.num1[31]}}, bus.num1}) * $signed({{32{bus.num2[31]}}, bus.num2});
  assign umul_s  = {32'd0, bus.num1} * {32'd0, bus.num2};
  assign div0_s  = (bus.num2 == 32'd0);
  assign a_neg_s = bus.num1[31];
  assign b_neg_s = bus.num2[31];
  assign abs_a_s = a_neg_s ? (32'd0 - bus.num1) : bus.num1;
  assign abs_b_s = b_neg_s ? (32'd0 - bus.num2) : bus.num2;
  assign uq_s    = div0_s ? 32'd0 : (bus.num1 / bus.num2);
  assign ur_s    = div0_s ? 32'd0 : (bus.num1 % bus.num2);
  assign mq_s    = div0_s ? 32'd0 : (abs_a_s / abs_b_s);
  assign mr_s    = div0_s ? 32'd0 : (abs_a_s % abs_b_s);
  assign sq_s    = (a_neg_s ^ b_neg_s) ? (32'd0 - mq_s) : mq_s;
  assign sr_s    = a_neg_s ? (32'd0 - mr_s) : mr_s;

  always_comb begin
    case (bus.md_op)
      OP_MFHI: rd_data_s = hi_q;
      OP_MFLO: rd_data_s = lo_q;
      default: rd_data_s = 32'd0;
    endcase
  end

  // Accept in IDLE, count down in RUN, commit pending HI/LO on the last cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    case (state_q)
      IDLE: begin
        if (bus.start && !bus.req) begin
          case (bus.md_op)
            OP_MULT: begin
              {pend_hi_d, pend_lo_d} = smul_s;
              pend_wr_d = 1'b1;
              cnt_d     = MULT_LOAD;
              state_d   = RUN;
            end
            OP_MULTU: begin
              {pend_hi_d, pend_lo_d} = umul_s;
              pend_wr_d = 1'b1;
              cnt_d     = MULT_LOAD;
              state_d   = RUN;
            end
            OP_DIV: begin
              pend_hi_d = sr_s;
              pend_lo_d = sq_s;
              pend_wr_d = !div0_s;
              cnt_d     = DIV_LOAD;
              state_d   = RUN;
            end
            OP_DIVU: begin
              pend_hi_d = ur_s;
              pend_lo_d = uq_s;
              pend_wr_d = !div0_s;
              cnt_d     = DIV_LOAD;
              state_d   = RUN;
            end
            OP_MTHI: hi_d = bus.num1;
            OP_MTLO: lo_d = bus.num1;
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
              case (bus.md_op)
                OP_MADD:  {pend_hi_d, pend_lo_d} = {hi_q, lo_q} + smul_s;
                OP_MADDU: {pend_hi_d, pend_lo_d} = {hi_q, lo_q} + umul_s;
                OP_MSUB:  {pend_hi_d, pend_lo_d} = {hi_q, lo_q} - smul_s;
                default:  {pend_hi_d, pend_lo_d} = {hi_q, lo_q} - umul_s;
              endcase
              pend_wr_d = 1'b1;
              cnt_d     = MULT_LOAD;
              state_d   = RUN;
            end
`endif
            default: state_d = IDLE;
          endcase
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (cnt_q == CNT_ONE) begin
          cnt_d   = CNT_ZERO;
          state_d = IDLE;
          if (pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end else begin
            hi_d = hi_q;
            lo_d = lo_q;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // State and architectural register update.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= CNT_ZERO;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
    end
  end

  assign bus.busy    = (state_q == RUN);
  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;
  assign bus.rd_data = rd_data_s;

endmodule

// File: tb/tb_mdu_ex.sv
// Scoreboard bench for mdu_ex: expected HI:LO queued at issue, checked at completion.
module tb_mdu_ex;
  localparam int MC = 5;
  localparam int DC = 10;

  logic clk = 1'b0;
  logic reset;
  mdu_ex_if mif();

  mdu_ex #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (mif)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] sb_q[$];
  logic [63:0] m_acc;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model_res(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [63:0] acc);
    longint sa, sb;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    up = {32'd0, a} * {32'd0, b};
    case (op)
      4'd1:  return 64'(sa * sb);
      4'd2:  return up;
      4'd3:  return (b == 32'd0) ? acc : {32'(sa % sb), 32'(sa / sb)};
      4'd4:  return (b == 32'd0) ? acc : {a % b, a / b};
      4'd9:  return acc + 64'(sa * sb);
      4'd10: return acc + up;
      4'd11: return acc - 64'(sa * sb);
      4'd12: return acc - up;
      default: return acc;
    endcase
  endfunction

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic rq);
    @(negedge clk);
    mif.start = 1'b1; mif.md_op = op; mif.num1 = a; mif.num2 = b; mif.req = rq;
    @(negedge clk);
    mif.start = 1'b0; mif.md_op = 4'd0; mif.req = 1'b0;
  endtask

  task automatic wait_done(input int n_exp, input int pre);
    int cnt;
    logic [63:0] exp;
    cnt = pre;
    while (mif.busy === 1'b1 && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
    check_val("busy_len", 64'(cnt), 64'(n_exp));
    check_val("sb_size", 64'(sb_q.size()), 64'd1);
    if (sb_q.size() != 0) begin
      exp = sb_q.pop_front();
      check_val("hilo", {mif.hi, mif.lo}, exp);
      mif.md_op = 4'd7; #1;
      check_val("mfhi", 64'(mif.rd_data), 64'(exp[63:32]));
      mif.md_op = 4'd8; #1;
      check_val("mflo", 64'(mif.rd_data), 64'(exp[31:0]));
      mif.md_op = 4'd0;
    end
  endtask

  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    m_acc = model_res(op, a, b, m_acc);
    sb_q.push_back(m_acc);
    drive(op, a, b, 1'b0);
    wait_done((op == 4'd3 || op == 4'd4) ? DC : MC, 0);
  endtask

  task automatic do_mt(input logic [3:0] op, input logic [31:0] a, input logic rq);
    drive(op, a, 32'd0, rq);
    if (!rq) begin
      if (op == 4'd5) m_acc[63:32] = a;
      else m_acc[31:0] = a;
    end
    check_val("mt_busy", 64'(mif.busy), 64'd0);
    check_val("mt_hilo", {mif.hi, mif.lo}, m_acc);
  endtask

  initial begin
    mif.start = 1'b0; mif.md_op = 4'd0; mif.num1 = 32'd0; mif.num2 = 32'd0; mif.req = 1'b0;
    m_acc = 64'd0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    check_val("rst_busy", 64'(mif.busy), 64'd0);
    check_val("rst_hilo", {mif.hi, mif.lo}, 64'd0);
    mif.md_op = 4'd7; #1;
    check_val("rst_rd", 64'(mif.rd_data), 64'd0);
    mif.md_op = 4'd0;
    @(negedge clk) reset = 1'b1;

    do_op(4'd1, 32'hFFFFFFFE, 32'd3);
    check_val("mult_k", {mif.hi, mif.lo}, 64'hFFFFFFFF_FFFFFFFA);
    do_op(4'd2, 32'hFFFFFFFE, 32'd3);
    check_val("multu_k", {mif.hi, mif.lo}, 64'h00000002_FFFFFFFA);
    do_op(4'd3, 32'hFFFFFFF9, 32'd2);
    check_val("div_k", {mif.hi, mif.lo}, 64'hFFFFFFFF_FFFFFFFD);
    do_op(4'd3, 32'h80000000, 32'hFFFFFFFF);
    check_val("div_ovf", {mif.hi, mif.lo}, 64'h00000000_80000000);
    do_op(4'd4, 32'd100, 32'd7);
    check_val("divu_k", {mif.hi, mif.lo}, 64'h00000002_0000000E);

    do_mt(4'd5, 32'h11, 1'b0);
    do_mt(4'd6, 32'h22, 1'b0);
    do_op(4'd4, 32'd7, 32'd0);
    check_val("div0_k", {mif.hi, mif.lo}, 64'h00000011_00000022);
    mif.md_op = 4'd8; #1;
    check_val("mflo_k", 64'(mif.rd_data), 64'h22);
    mif.md_op = 4'd1; #1;
    check_val("rd_other", 64'(mif.rd_data), 64'd0);
    mif.md_op = 4'd0;

    do_mt(4'd6, 32'h55, 1'b1);
    check_val("mtlo_req", 64'(mif.lo), 64'h22);

    // second start during RUN must be dropped
    m_acc = model_res(4'd1, 32'd1000, 32'd3, m_acc);
    sb_q.push_back(m_acc);
    drive(4'd1, 32'd1000, 32'd3, 1'b0);
    mif.start = 1'b1; mif.md_op = 4'd1; mif.num1 = 32'd77; mif.num2 = 32'd77;
    @(negedge clk);
    mif.start = 1'b0; mif.md_op = 4'd0;
    wait_done(MC, 1);

    // req during RUN does not cancel
    m_acc = model_res(4'd2, 32'd1234, 32'd5678, m_acc);
    sb_q.push_back(m_acc);
    drive(4'd2, 32'd1234, 32'd5678, 1'b0);
    mif.req = 1'b1;
    @(negedge clk);
    mif.req = 1'b0;
    wait_done(MC, 1);

    drive(4'd13, 32'hABCD, 32'd2, 1'b0);
    check_val("undef_busy", 64'(mif.busy), 64'd0);
    check_val("undef_hilo", {mif.hi, mif.lo}, m_acc);

`ifdef MDU_MADD_EN
    do_mt(4'd5, 32'd0, 1'b0);
    do_mt(4'd6, 32'hFFFFFFFF, 1'b0);
    do_op(4'd9, 32'd1, 32'd1);
    check_val("madd_k", {mif.hi, mif.lo}, 64'h00000001_00000000);
    do_op(4'd11, 32'hFFFFFFFF, 32'd5);
    do_op(4'd10, 32'hFFFFFFFF, 32'd5);
    do_op(4'd12, 32'h80000000, 32'd3);
`else
    drive(4'd9, 32'd1, 32'd1, 1'b0);
    check_val("madd_off_busy", 64'(mif.busy), 64'd0);
    check_val("madd_off_hilo", {mif.hi, mif.lo}, m_acc);
`endif

    for (int i = 0; i < 8; i++) begin
      logic [3:0] op;
      logic [31:0] a, b;
      op = 4'($urandom_range(1, 4));
      a  = $urandom;
      b  = (i % 4 == 3) ? 32'd0 : ((i % 2 == 0) ? $urandom : 32'($urandom_range(1, 300)));
      do_op(op, a, b);
    end

    // asynchronous reset in the middle of a divide
    do_mt(4'd5, 32'hDEADBEEF, 1'b0);
    drive(4'd3, 32'd100, 32'd7, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check_val("rst_run_busy", 64'(mif.busy), 64'd0);
    check_val("rst_run_hilo", {mif.hi, mif.lo}, 64'd0);
    @(negedge clk) reset = 1'b1;
    m_acc = 64'd0;
    do_op(4'd1, 32'd6, 32'd7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mdu_ex.md
Name: mdu_ex

Overview:
- Multiply/divide unit for the EX stage of the 5-stage MIPS pipeline.
- Consumes the operands and instruction already latched into the ID/EX pipeline registers (E_Num1 = GPR[rs], E_Num2 = GPR[rt]). Holds the architectural HI/LO registers.
- Produces a busy flag to the hazard unit, and the mfhi/mflo read value that is forwarded into the EX/MEM register.
- Multi-cycle operation with cancel-on-exception, for the P7 exception flow.

Parameters:
- MULT_CYCLES, 5, busy duration for mult/multu (and madd family when enabled), >=1.
- DIV_CYCLES, 10, busy duration for div/divu, >=1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  reset, asynchronous, active-low; state clears while low.
- start  in  1  EX holds a valid MDU instruction this cycle.
- md_op  in  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo, 9 madd, 10 maddu, 11 msub, 12 msubu.
- num1  in  32  E_Num1 (rs).
- num2  in  32  E_Num2 (rt).
- req  in  1  exception/interrupt being taken in MEM this cycle; cancels EX.
- busy  out  1  an operation is in progress.
- hi  out  32  HI register.
- lo  out  32  LO register.
- rd_data  out  32  combinational read value: hi for op 7, lo for op 8, else 0.

Behaviour:
- Reset (reset low, asynchronous): hi=0, lo=0, busy=0, counter=0, pending results=0, state IDLE.
- States: IDLE, RUN.
- An op is accepted at the rising edge where start=1, req=0, state=IDLE, and md_op is one of 1-6 or 9-12. Undefined md_op values (13-15) are ignored.
- mthi/mtlo:
  - Written at the accepting edge: hi<=num1 or lo<=num1.
  - busy stays 0.
- mult/multu/div/divu (and madd family) at the accepting edge:
  - Compute the result into internal pending regs.
  - Load counter with MULT_CYCLES or DIV_CYCLES.
  - Go to RUN.
- RUN:
  - busy=1 for exactly N cycles after the accepting edge.
  - Counter decrements each edge.
  - At the edge where counter==1: hi/lo take the pending values, counter goes to 0, state goes to IDLE, busy=0 from that edge on.
  - hi/lo are unchanged throughout RUN.
- Arithmetic:
  - mult: signed 32x32->64, {hi,lo}=product.
  - multu: unsigned 32x32->64, {hi,lo}=product.
  - div: lo=quotient, hi=remainder, truncating toward zero; remainder takes the sign of the dividend.
  - divu: unsigned division, lo=quotient, hi=remainder.
  - Overflow case 0x80000000/-1: lo=0x80000000, hi=0.
- Divide by zero: the op is accepted and busy runs the full DIV_CYCLES, but hi/lo are left unchanged at completion.
- start while busy (state RUN): ignored, no effect. The hazard unit stalls on (start & busy) or on a start in the accept cycle, so this does not occur in normal flow.
- req=1 together with start: op not accepted, no state change, mthi/mtlo suppressed.
- req while RUN: the running op continues and commits.
- reset low mid-RUN: immediate abort; all state returns to reset values.
- rd_data is purely combinational from md_op and the current hi/lo. mfhi issued the cycle after busy falls reads the new value.

Optional Feature:
- MDU_MADD_EN defined:
  - Ops 9-12 supported: {hi,lo} <= {hi,lo} ± product. madd/msub use the signed product, maddu/msubu the unsigned product.
  - The 64-bit accumulate is modulo 2^64.
  - The accumulator base is the hi/lo value at the accepting edge.
  - Latency is MULT_CYCLES.
- MDU_MADD_EN undefined: ops 9-12 are treated as undefined, ignored, busy stays 0, no state change.

Test Plan:
- Reset: reset low mid-RUN of div -> busy=0, hi=0, lo=0 immediately.
- mult num1=0xFFFFFFFE, num2=3 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- multu with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- div num1=-7 (0xFFFFFFF9), num2=2 -> busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- divu 7/0 with hi=0x11, lo=0x22 preloaded via mthi/mtlo -> busy 10 cycles, then hi=0x11, lo=0x22 unchanged. mflo afterwards -> rd_data=0x22.
- mtlo num1=0x55 with req=1 -> lo unchanged.
- mult start asserted during busy -> ignored; hi/lo reflect only the first op.
- With MDU_MADD_EN, hi=0, lo=0xFFFFFFFF, madd 1*1 -> hi=1, lo=0.
